// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg
// Shared definitions for the mantissa normalizer:
//   - datapath widths (mantissa sum, biased exponent, stored fraction)
//   - saturated exponent value
//   - the normalizer state encoding
//   - bit positions inside the 26-bit saved mantissa sum
package fp_norm_pkg;

  localparam int MANT_W = 26;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  // Layout of the saved mantissa sum: carry | hidden | fraction | guard
  localparam int CARRY_BIT  = 25;
  localparam int HIDDEN_BIT = 24;
  localparam int LSB_BIT    = 1;
  localparam int GUARD_BIT  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_SHIFT_L = 3'd2,
    ST_SHIFT_R = 3'd3,
    ST_ROUND   = 3'd4,
    ST_DONE    = 3'd5
  } norm_state_t;

endpackage

// File: rtl/round_rne.sv
// round_rne
// Combinational round-to-nearest-even for a 26-bit mantissa whose bit0 is
// the guard bit and bit1 the result lsb.
// Ports:
//   mant    in  26  mantissa to round (carry bit expected clear)
//   sticky  in  1   OR of all bits already shifted out below the guard
//   rounded out 26  rounded mantissa, guard position cleared
//   carry   out 1   rounding rippled into the carry bit
module round_rne
  import fp_norm_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              sticky,
  output logic [MANT_W-1:0] rounded,
  output logic              carry
);

  logic              inc;
  logic [MANT_W-2:0] upper;

  // Round up above half, and on an exact half only when the lsb is odd.
  assign inc     = mant[GUARD_BIT] & (sticky | mant[LSB_BIT]);
  assign upper   = mant[MANT_W-1:LSB_BIT] + {{(MANT_W-2){1'b0}}, inc};
  assign rounded = {upper, 1'b0};
  assign carry   = rounded[CARRY_BIT];

endmodule

// File: rtl/normalizare_26b.sv
// normalizare_26b
// Sequential normalizer for the adder's saved mantissa sum. Shifts one bit
// per cycle until the hidden bit sits at bit 24, adjusts the exponent,
// rounds, and presents packed single-precision fields with status flags.
// Build option: ROUND_NEAREST_EN selects round-to-nearest-even; without it
// the result is truncated (the ROUND state is visited either way).
// Ports:
//   clk             in  1   rising-edge clock
//   clear           in  1   synchronous active-high reset
//   start           in  1   request, sampled only when idle
//   saved_mant_sum  in  26  carry | hidden | fraction[23:1] | guard
//   exp_in          in  8   biased exponent before normalization
//   sign_in         in  1   result sign
//   busy            out 1   operation in progress
//   consumed        out 1   pulse: input register may be cleared/reloaded
//   done            out 1   pulse: result fields valid from this cycle
//   frac_out/exp_out/sign_out  out 23/8/1  result, held until next done
//   zero/overflow/underflow    out 1 each  status, held with the result
module normalizare_26b
  import fp_norm_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [MANT_W-1:0] saved_mant_sum,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              sign_in,
  output logic              busy,
  output logic              consumed,
  output logic              done,
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sign_out,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  norm_state_t       state_reg, state_next;
  logic [MANT_W-1:0] mant_reg, mant_next;
  logic [EXP_W-1:0]  exp_reg, exp_next;
  logic              sign_reg, sign_next;
  logic              zero_reg, zero_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;

  logic              done_reg, consumed_reg;
  logic [FRAC_W-1:0] frac_out_reg;
  logic [EXP_W-1:0]  exp_out_reg;
  logic              sign_out_reg, zero_out_reg, ovf_out_reg, unf_out_reg;

  logic [MANT_W-1:0] rnd_mant;
  logic              rnd_carry;

`ifdef ROUND_NEAREST_EN
  logic sticky_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      sticky_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && start) begin
      sticky_reg <= 1'b0;
    end else if (state_reg == ST_SHIFT_R) begin
      sticky_reg <= sticky_reg | mant_reg[GUARD_BIT];
    end
  end

  round_rne u_round_rne (
    .mant    (mant_reg),
    .sticky  (sticky_reg),
    .rounded (rnd_mant),
    .carry   (rnd_carry)
  );
`else
  assign rnd_mant  = mant_reg;
  assign rnd_carry = mant_reg[CARRY_BIT];
`endif

  always_comb begin
    state_next = state_reg;
    mant_next  = mant_reg;
    exp_next   = exp_reg;
    sign_next  = sign_reg;
    zero_next  = zero_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mant_next  = saved_mant_sum;
          // Exponent field 0 means the same scale as 1 (denormal range).
          exp_next   = (exp_in == '0) ? 8'd1 : exp_in;
          sign_next  = sign_in;
          zero_next  = 1'b0;
          ovf_next   = 1'b0;
          unf_next   = 1'b0;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (exp_reg == EXP_MAX) begin
          ovf_next   = 1'b1;
          mant_next  = '0;
          state_next = ST_DONE;
        end else if (mant_reg == '0) begin
          zero_next  = 1'b1;
          exp_next   = '0;
          state_next = ST_DONE;
        end else if (mant_reg[CARRY_BIT]) begin
          state_next = ST_SHIFT_R;
        end else if (mant_reg[HIDDEN_BIT] || exp_reg <= 8'd1) begin
          // Already normalized, or already at the exponent floor.
          state_next = ST_ROUND;
        end else begin
          state_next = ST_SHIFT_L;
        end
      end
      ST_SHIFT_R: begin
        mant_next = mant_reg >> 1;
        exp_next  = exp_reg + 8'd1;
        if (exp_reg == EXP_MAX - 8'd1) begin
          ovf_next  = 1'b1;
          mant_next = '0;
        end
        // Overflow still passes through ROUND (untouched) so the
        // right-shift path has one fixed latency.
        state_next = ST_ROUND;
      end
      ST_SHIFT_L: begin
        mant_next = mant_reg << 1;
        exp_next  = exp_reg - 8'd1;
        if (mant_reg[HIDDEN_BIT-1] || exp_reg == 8'd2) begin
          state_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (!ovf_reg) begin
          if (rnd_carry) begin
            mant_next = rnd_mant >> 1;
            exp_next  = exp_reg + 8'd1;
            if (exp_reg == EXP_MAX - 8'd1) begin
              ovf_next  = 1'b1;
              mant_next = '0;
            end
          end else begin
            mant_next = rnd_mant;
            // No hidden bit after rounding: denormal. A denormal that
            // rounded up into bit24 keeps exponent 1 and is normal.
            if (!rnd_mant[HIDDEN_BIT]) begin
              exp_next = '0;
              unf_next = 1'b1;
            end
          end
        end
        state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg    <= ST_IDLE;
      mant_reg     <= '0;
      exp_reg      <= '0;
      sign_reg     <= 1'b0;
      zero_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
      done_reg     <= 1'b0;
      consumed_reg <= 1'b0;
      frac_out_reg <= '0;
      exp_out_reg  <= '0;
      sign_out_reg <= 1'b0;
      zero_out_reg <= 1'b0;
      ovf_out_reg  <= 1'b0;
      unf_out_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mant_reg     <= mant_next;
      exp_reg      <= exp_next;
      sign_reg     <= sign_next;
      zero_reg     <= zero_next;
      ovf_reg      <= ovf_next;
      unf_reg      <= unf_next;
      done_reg     <= (state_reg == ST_DONE);
      // The input register was captured two edges ago and is no longer read.
      consumed_reg <= (state_reg == ST_CHECK);
      if (state_reg == ST_DONE) begin
        frac_out_reg <= mant_reg[HIDDEN_BIT-1:LSB_BIT];
        exp_out_reg  <= exp_reg;
        sign_out_reg <= sign_reg;
        zero_out_reg <= zero_reg;
        ovf_out_reg  <= ovf_reg;
        unf_out_reg  <= unf_reg;
      end
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign consumed  = consumed_reg;
  assign done      = done_reg;
  assign frac_out  = frac_out_reg;
  assign exp_out   = exp_out_reg;
  assign sign_out  = sign_out_reg;
  assign zero      = zero_out_reg;
  assign overflow  = ovf_out_reg;
  assign underflow = unf_out_reg;

endmodule

// File: tb/tb_normalizare_26b.sv
// tb_normalizare_26b
// Directed bench for normalizare_26b. A value-level model (leading-one
// search, integer rounding) predicts each result and latency; the test
// plan vectors are also checked against hand-computed literals.
module tb_normalizare_26b;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [25:0] saved_mant_sum = '0;
  logic [7:0]  exp_in = '0;
  logic        sign_in = 1'b0;
  logic        busy, consumed, done;
  logic [22:0] frac_out;
  logic [7:0]  exp_out;
  logic        sign_out, zero, overflow, underflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  normalizare_26b dut (
    .clk            (clk),
    .clear          (clear),
    .start          (start),
    .saved_mant_sum (saved_mant_sum),
    .exp_in         (exp_in),
    .sign_in        (sign_in),
    .busy           (busy),
    .consumed       (consumed),
    .done           (done),
    .frac_out       (frac_out),
    .exp_out        (exp_out),
    .sign_out       (sign_out),
    .zero           (zero),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Value-level model: find the leading one, move it to bit 24 within the
  // exponent floor, round on integers, then classify.
  function automatic void model(input logic [25:0] m_in, input logic [7:0] e_in,
                                output int lat, output logic [22:0] f,
                                output logic [7:0] eo, output logic [2:0] flags);
    int          e, p, n;
    logic [26:0] m;
    logic        st;
    f = '0; flags = 3'b000; eo = '0; lat = 0;
    if (e_in == 8'd255) begin lat = 2; eo = 8'd255; flags = 3'b010; return; end
    if (m_in == '0)     begin lat = 2; flags = 3'b100; return; end
    e  = (e_in == 8'd0) ? 1 : int'(e_in);
    m  = {1'b0, m_in};
    st = 1'b0;
    if (m_in[25]) begin
      st = m[0]; m = m >> 1; e = e + 1; lat = 4;
      if (e == 255) begin eo = 8'd255; flags = 3'b010; return; end
    end else if (m_in[24]) begin
      lat = 3;
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (m_in[i]) p = i;
      n = 24 - p;
      if (n > e - 1) n = e - 1;
      m = m << n; e = e - n; lat = 3 + n;
    end
`ifdef ROUND_NEAREST_EN
    if (m[0] && (st || m[1])) m = m + 27'd2;
`endif
    if (m[25]) begin
      m = m >> 1; e = e + 1;
      if (e == 255) begin eo = 8'd255; flags = 3'b010; return; end
    end
    if (!m[24]) begin flags = 3'b001; e = 0; end
    eo = 8'(e);
    f  = m[23:1];
  endfunction

  task automatic run(input string tag, input logic [25:0] m, input logic [7:0] e, input logic s,
                     input bit lit, input int l_lat, input logic [22:0] l_frac,
                     input logic [7:0] l_exp, input logic [2:0] l_flags);
    int          m_lat, cyc, busy_bad, cons_cnt, cons_at;
    logic [22:0] m_f;
    logic [7:0]  m_e;
    logic [2:0]  m_fl, d_fl;
    bit          got;
    model(m, e, m_lat, m_f, m_e, m_fl);
    @(negedge clk);
    saved_mant_sum = m; exp_in = e; sign_in = s; start = 1'b1;
    @(posedge clk); #1;
    // Scramble the inputs to show they were captured.
    start = 1'b0; saved_mant_sum = ~m; exp_in = ~e; sign_in = ~s;
    cyc = 0; got = 0; busy_bad = 0; cons_cnt = 0; cons_at = -1;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 1);  // stray request, sampled while busy
      if (consumed) begin cons_cnt++; cons_at = cyc; end
      if (done) begin got = 1; if (busy) busy_bad++; end
      else if (!busy) busy_bad++;
    end
    start = 1'b0;
    d_fl = {zero, overflow, underflow};
    $display("txn %s mant=%h exp=%0d sign=%0d -> cyc=%0d frac=%h exp=%0d sign=%0d zou=%b",
             tag, m, e, s, got ? cyc : -1, frac_out, exp_out, sign_out, d_fl);
    chk({tag, " latency"}, got ? cyc : -1, m_lat);
    chk({tag, " frac"}, frac_out, m_f);
    chk({tag, " exp"}, exp_out, m_e);
    chk({tag, " sign"}, sign_out, s);
    chk({tag, " flags"}, d_fl, m_fl);
    chk({tag, " busy"}, busy_bad, 0);
    chk({tag, " consumed count"}, cons_cnt, 1);
    chk({tag, " consumed cycle"}, cons_at, 1);
    if (lit) begin
      chk({tag, " lit latency"}, got ? cyc : -1, l_lat);
      chk({tag, " lit frac"}, frac_out, l_frac);
      chk({tag, " lit exp"}, exp_out, l_exp);
      chk({tag, " lit flags"}, d_fl, l_flags);
    end
    @(posedge clk); #1;
    chk({tag, " done width"}, done, 0);
    chk({tag, " hold"}, {frac_out, exp_out}, {m_f, m_e});
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {busy, consumed, done, frac_out, exp_out, sign_out, zero, overflow, underflow}, 0);
    clear = 1'b0;

    run("normalized", 26'h1000000, 8'd127, 1'b1, 1, 3, 23'h0, 8'd127, 3'b000);
`ifdef ROUND_NEAREST_EN
    run("shr_round", 26'h2000006, 8'd127, 1'b0, 1, 4, 23'h2, 8'd128, 3'b000);
`else
    run("shr_round", 26'h2000006, 8'd127, 1'b0, 1, 4, 23'h1, 8'd128, 3'b000);
`endif
    run("shl15", 26'h0000200, 8'd127, 1'b0, 1, 18, 23'h0, 8'd112, 3'b000);
    run("zero", 26'h0000000, 8'd90, 1'b0, 1, 2, 23'h0, 8'd0, 3'b100);
    run("underflow", 26'h0010000, 8'd3, 1'b1, 1, 5, 23'h20000, 8'd0, 3'b001);

    // clear in the middle of a left-shift sequence
    @(negedge clk);
    saved_mant_sum = 26'h0000200; exp_in = 8'd127; sign_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear outputs", {busy, consumed, done, frac_out, exp_out, sign_out, zero, overflow, underflow}, 0);
    bad = 0;
    repeat (2) begin @(posedge clk); #1; if (busy || done) bad++; end
    chk("clear stays idle", bad, 0);
    $display("txn clear_mid_shift idle_errors=%0d", bad);

    run("overflow_shr", 26'h2000000, 8'd254, 1'b0, 1, 4, 23'h0, 8'd255, 3'b010);

    // clear and start together: start is discarded
    @(negedge clk);
    saved_mant_sum = 26'h1000000; exp_in = 8'd10; sign_in = 1'b1; start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    bad = 0;
    repeat (5) begin @(posedge clk); #1; if (busy || done || consumed) bad++; end
    chk("clear beats start", bad, 0);
    $display("txn clear_with_start activity=%0d", bad);

    run("all_ones", 26'h3FFFFFF, 8'd100, 1'b1, 0, 0, 23'h0, 8'd0, 3'b000);
    run("denorm_e1", 26'h0FFFFFF, 8'd1, 1'b0, 0, 0, 23'h0, 8'd0, 3'b000);
    run("denorm_e0", 26'h0FFFFFF, 8'd0, 1'b1, 0, 0, 23'h0, 8'd0, 3'b000);
    run("round_to_max", 26'h1FFFFFF, 8'd254, 1'b0, 0, 0, 23'h0, 8'd0, 3'b000);
    run("shl24", 26'h0000001, 8'd127, 1'b0, 1, 27, 23'h0, 8'd103, 3'b000);
    run("exp_max_in", 26'h1234567, 8'd255, 1'b1, 1, 2, 23'h0, 8'd255, 3'b010);
    run("floor_stop", 26'h0000003, 8'd10, 1'b0, 1, 12, 23'h300, 8'd0, 3'b001);
    run("tie_even", 26'h1800001, 8'd50, 1'b0, 1, 3, 23'h400000, 8'd50, 3'b000);
    run("tie_odd", 26'h1800003, 8'd50, 1'b0, 0, 0, 23'h0, 8'd0, 3'b000);
    run("sticky_shr", 26'h2000003, 8'd50, 1'b1, 0, 0, 23'h0, 8'd0, 3'b000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
